mem_req_arbiter: RTL and testbench

Upstream request stage for the PSRAM memory controller. Accepts single-byte read/write requests from the CPU port and read-only requests from the VIC port, arbitrates between them, and drives the controller's CE/write/bank/address/data request interface. It tracks the controller's `busy` handshake, captures read data, and returns a one-cycle acknowledge to the winning requester. A watchdog flags a controller that never accepts a request.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the PSRAM request arbiter: FSM states,
// requester identities and the controller byte-count encodings.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VIC = 1'b1
  } req_id_t;

  localparam logic [3:0] NBYTES_READ  = 4'd0;
  localparam logic [3:0] NBYTES_WRITE = 4'd1;

  // A lone requester always wins; on conflict the one not served last wins.
  function automatic req_id_t arb_pick(input logic    cpu_req,
                                       input logic    vic_req,
                                       input req_id_t last_grant);
    if (cpu_req && vic_req) return (last_grant == REQ_CPU) ? REQ_VIC : REQ_CPU;
    else if (vic_req)       return REQ_VIC;
    else                    return REQ_CPU;
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Upstream request stage for the PSRAM controller: arbitrates CPU (read/write)
// and VIC (read) byte requests, tracks mc_busy, captures read data and acks.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = 8,
  parameter int unsigned TO_W          = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vic_req,
  input  logic [15:0] vic_addr,
  output logic [7:0]  vic_rdata,
  output logic        vic_ack,
  input  logic [6:0]  bank_cfg,
  output logic        mc_ce,
  output logic        mc_write,
  output logic [6:0]  mc_bank,
  output logic [15:0] mc_addr,
  output logic [3:0]  mc_nbytes,
  output logic [7:0]  mc_wdata,
  input  logic [7:0]  mc_rdata,
  input  logic        mc_busy,
  output logic        init_done,
  output logic        err_timeout
);

  state_t          r_state;
  req_id_t         r_last_grant;
  req_id_t         r_gnt_id;
  logic            r_we;
  logic [15:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [6:0]      r_bank;
  logic [3:0]      r_nbytes;
  logic [TO_W-1:0] r_wdog;
  logic            r_init_done;
  logic            r_err_timeout;
  logic            r_mc_ce;
  logic            r_mc_write;
  logic            r_cpu_ack;
  logic            r_vic_ack;
  logic [7:0]      r_cpu_rdata;
  logic [7:0]      r_vic_rdata;

  req_id_t         w_pick;
  logic            w_grant;
  logic [TO_W-1:0] w_wdog_next;
  logic            w_wdog_expired;

  assign w_pick         = arb_pick(cpu_req, vic_req, r_last_grant);
  assign w_grant        = r_init_done && !mc_busy && (cpu_req || vic_req);
  assign w_wdog_next    = r_wdog + 1'b1;
  assign w_wdog_expired = (w_wdog_next == TO_W'(START_TIMEOUT));

  // NOTE: state and outputs are updated with non-blocking assignments only, so
  // every branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data latches and rdata registers are reset as well, because
      // every output must read zero after reset, not just the control state.
      r_state       <= ST_IDLE;
      r_last_grant  <= REQ_CPU;
      r_gnt_id      <= REQ_CPU;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_bank        <= '0;
      r_nbytes      <= NBYTES_READ;
      r_wdog        <= '0;
      r_init_done   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_mc_ce       <= 1'b0;
      r_mc_write    <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_vic_ack     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_vic_rdata   <= '0;
    end else begin
      // NOTE: single-cycle strobes default low here and are raised only in the
      // one state that owns them, so no branch can leave them stuck high.
      r_mc_ce   <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_vic_ack <= 1'b0;

      if (!mc_busy) r_init_done <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt_id <= w_pick;
            r_bank   <= bank_cfg;
            r_wdog   <= '0;
            r_mc_ce  <= 1'b1;
            if (w_pick == REQ_VIC) begin
              r_we       <= 1'b0;
              r_addr     <= vic_addr;
              r_wdata    <= '0;
              r_nbytes   <= NBYTES_READ;
              r_mc_write <= 1'b0;
            end else begin
              r_we       <= cpu_we;
              r_addr     <= cpu_addr;
              r_wdata    <= cpu_wdata;
              r_nbytes   <= cpu_we ? NBYTES_WRITE : NBYTES_READ;
              r_mc_write <= cpu_we;
            end
            r_state <= ST_ISSUE;
          end
        end

        // busy seen during ISSUE belongs to a previous phase; only WAIT_START counts it.
        ST_ISSUE: r_state <= ST_WAIT_START;

        ST_WAIT_START: begin
          if (mc_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_wdog_expired) begin
            r_err_timeout <= 1'b1;
            r_wdog        <= '0;
            r_mc_write    <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_wdog <= w_wdog_next;
          end
        end

        ST_WAIT_DONE: begin
          if (!mc_busy) begin
            if (r_gnt_id == REQ_CPU) begin
              if (!r_we) r_cpu_rdata <= mc_rdata;
              r_cpu_ack <= 1'b1;
            end else begin
              if (!r_we) r_vic_rdata <= mc_rdata;
              r_vic_ack <= 1'b1;
            end
            r_last_grant <= r_gnt_id;
            r_mc_write   <= 1'b0;
            r_state      <= ST_RESP;
          end
        end

        ST_RESP: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign vic_rdata   = r_vic_rdata;
  assign vic_ack     = r_vic_ack;
  assign mc_ce       = r_mc_ce;
  assign mc_write    = r_mc_write;
  assign mc_bank     = r_bank;
  assign mc_addr     = r_addr;
  assign mc_nbytes   = r_nbytes;
  assign mc_wdata    = r_wdata;
  assign init_done   = r_init_done;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a behavioural PSRAM controller, a
// transaction-level reference model and a monitor that checks every strobe/ack.
module tb_mem_req_arbiter;

  localparam int unsigned START_TIMEOUT = 8;
  localparam int unsigned TO_W          = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        vic_req = 1'b0;
  logic [15:0] vic_addr = '0;
  logic [7:0]  vic_rdata;
  logic        vic_ack;
  logic [6:0]  bank_cfg = '0;
  logic        mc_ce;
  logic        mc_write;
  logic [6:0]  mc_bank;
  logic [15:0] mc_addr;
  logic [3:0]  mc_nbytes;
  logic [7:0]  mc_wdata;
  logic [7:0]  mc_rdata;
  logic        mc_busy;
  logic        init_done;
  logic        err_timeout;

  mem_req_arbiter #(.START_TIMEOUT(START_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vic_req(vic_req), .vic_addr(vic_addr), .vic_rdata(vic_rdata), .vic_ack(vic_ack),
    .bank_cfg(bank_cfg),
    .mc_ce(mc_ce), .mc_write(mc_write), .mc_bank(mc_bank), .mc_addr(mc_addr),
    .mc_nbytes(mc_nbytes), .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_busy(mc_busy),
    .init_done(init_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          who;    // 0 = CPU, 1 = VIC
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [6:0]  bank;
  } ce_exp_t;

  typedef struct {
    bit         who;
    logic [7:0] cpu_rd;
    logic [7:0] vic_rd;
  } ack_exp_t;

  ce_exp_t  exp_ce[$];
  ack_exp_t exp_ack[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ce_cyc = -1;
  int ack_cyc = -1;
  int ack_count = 0;
  int err_cyc = -1;

  // Reference model state: transaction-level view of the system.
  logic [7:0] model_mem [logic [15:0]];
  bit         model_last = 1'b0;
  logic [7:0] model_rd_cpu = '0;
  logic [7:0] model_rd_vic = '0;

  // Behavioural controller state.
  logic [7:0] ctl_mem [logic [15:0]];
  int         ctl_b = 1;
  bit         ctl_respond = 1'b1;
  int         ctl_init_len = 100;

  function automatic logic [7:0] bg(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : bg(a);
  endfunction

  function automatic logic [7:0] ctl_read(input logic [15:0] a);
    return ctl_mem.exists(a) ? ctl_mem[a] : bg(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic predict(input bit who, input bit we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [6:0] bank);
    ce_exp_t  c;
    ack_exp_t a;
    c.who = who; c.we = we; c.addr = addr; c.wdata = wdata; c.bank = bank;
    exp_ce.push_back(c);
    if (we) model_mem[addr] = wdata;
    else if (who) model_rd_vic = model_read(addr);
    else model_rd_cpu = model_read(addr);
    a.who = who; a.cpu_rd = model_rd_cpu; a.vic_rd = model_rd_vic;
    exp_ack.push_back(a);
    model_last = who;
  endtask

  task automatic predict_cpu();
    predict(1'b0, cpu_we, cpu_addr, cpu_wdata, bank_cfg);
  endtask

  task automatic predict_vic();
    predict(1'b1, 1'b0, vic_addr, 8'h00, bank_cfg);
  endtask

  task automatic issue_round(input bit c_on, input bit v_on);
    if (c_on && v_on) begin
      if (model_last == 1'b0) begin predict_vic(); predict_cpu(); end
      else                    begin predict_cpu(); predict_vic(); end
    end else if (c_on) predict_cpu();
    else               predict_vic();
    cpu_req = c_on;
    vic_req = v_on;
  endtask

  // Runs the requester side until n acks arrive; each req drops at the edge after its ack.
  task automatic serve(input bit hold, input int n, input int budget);
    int got;
    int cnt;
    bit c_done;
    bit v_done;
    got = 0;
    cnt = 0;
    while (got < n && cnt < budget) begin
      @(negedge clk);
      c_done = (cpu_ack === 1'b1);
      v_done = (vic_ack === 1'b1);
      got += int'(c_done) + int'(v_done);
      cnt++;
      @(posedge clk); #1;
      if (hold) begin
        if (got >= n) begin cpu_req = 1'b0; vic_req = 1'b0; end
      end else begin
        if (c_done) cpu_req = 1'b0;
        if (v_done) vic_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    vic_req = 1'b0;
    check("serve_ack_count", got, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PSRAM controller model: init busy after reset, then B busy cycles per accepted strobe.
  initial begin
    bit          start;
    bit          rst_s;
    int          init_cnt;
    int          busy_cnt;
    logic [15:0] op_addr;
    bit          op_we;
    logic [7:0]  op_wdata;
    init_cnt = 0; busy_cnt = 0; op_addr = '0; op_we = 1'b0; op_wdata = '0;
    mc_busy = 1'b1;
    mc_rdata = '0;
    forever begin
      @(negedge clk);
      rst_s = (reset === 1'b1);
      start = 1'b0;
      if (!rst_s && mc_ce === 1'b1 && ctl_respond) begin
        start = 1'b1; op_addr = mc_addr; op_we = mc_write; op_wdata = mc_wdata;
      end
      @(posedge clk); #2;
      if (rst_s) begin
        mc_busy = 1'b1; init_cnt = ctl_init_len; busy_cnt = 0;
      end else if (init_cnt > 0) begin
        init_cnt--;
        mc_busy = (init_cnt != 0);
      end else if (start) begin
        mc_busy = 1'b1; busy_cnt = ctl_b;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          if (op_we) ctl_mem[op_addr] = op_wdata;
          else       mc_rdata = ctl_read(op_addr);
          mc_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes the controller or acks.
  initial forever begin
    ce_exp_t  c;
    ack_exp_t a;
    @(negedge clk);
    if (reset !== 1'b0) continue;
    if (mc_ce === 1'b1) begin
      last_ce_cyc = cyc;
      if (exp_ce.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ce: got strobe addr 0x%0h, expected none (cycle %0d)", mc_addr, cyc);
      end else begin
        c = exp_ce.pop_front();
        check("ce_init_done", init_done, 1);
        check("ce_write", mc_write, c.we);
        check("ce_addr", mc_addr, c.addr);
        check("ce_bank", mc_bank, c.bank);
        check("ce_nbytes", mc_nbytes, c.we ? 4'd1 : 4'd0);
        if (c.we) check("ce_wdata", mc_wdata, c.wdata);
      end
    end
    if (cpu_ack === 1'b1 || vic_ack === 1'b1) begin
      ack_cyc = cyc;
      ack_count++;
      if (exp_ack.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got cpu_ack=%0b vic_ack=%0b, expected none (cycle %0d)", cpu_ack, vic_ack, cyc);
      end else begin
        a = exp_ack.pop_front();
        check("ack_cpu", cpu_ack, !a.who);
        check("ack_vic", vic_ack, a.who);
        check("cpu_rdata", cpu_rdata, a.cpu_rd);
        check("vic_rdata", vic_rdata, a.vic_rd);
      end
    end
    if (err_timeout === 1'b1 && err_cyc < 0) err_cyc = cyc;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int rel;
    int n0;
    int kind;
    int acks_before;
    int wait_cnt;

    // Init hold-off: request pending while the controller is busy initialising.
    ctl_init_len = 100;
    ctl_b = 2;
    cpu_we = 1'b0; cpu_addr = 16'h1234; bank_cfg = 7'h03;
    predict_cpu();
    cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rel = cyc;
    reset = 1'b0;
    serve(1'b0, 1, 300);
    check("init_first_ce_cycle", last_ce_cyc, rel + 102);

    // Directed CPU write with B = 3 and latency check.
    ctl_init_len = 4;
    idle(3);
    ctl_b = 3;
    cpu_we = 1'b1; cpu_addr = 16'hD020; cpu_wdata = 8'h0E; bank_cfg = 7'h05;
    n0 = cyc;
    issue_round(1'b1, 1'b0);
    serve(1'b0, 1, 100);
    check("wr_ce_latency", last_ce_cyc - n0, 1);
    check("wr_ack_latency", ack_cyc - n0, 6);

    // Directed VIC read returning 0x41.
    idle(2);
    ctl_mem[16'h0400] = 8'h41;
    model_mem[16'h0400] = 8'h41;
    ctl_b = 1;
    vic_addr = 16'h0400; bank_cfg = 7'h02;
    issue_round(1'b0, 1'b1);
    serve(1'b0, 1, 100);
    check("vic_read_0400", vic_rdata, 8'h41);

    // Randomised rounds: single requesters and same-cycle conflicts.
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      ctl_b = $urandom_range(1, 4);
      bank_cfg = 7'($urandom_range(0, 127));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'h2000 + 16'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      vic_addr = 16'h2000 + 16'($urandom_range(0, 15));
      issue_round(kind != 1, kind != 0);
      serve(1'b0, (kind == 2) ? 2 : 1, 100);
    end

    // Watchdog: controller ignores the strobe, the request is retried.
    idle(2);
    ctl_respond = 1'b0;
    ctl_b = 2;
    vic_addr = 16'h3000; bank_cfg = 7'h11;
    begin
      ce_exp_t d;
      d.who = 1'b1; d.we = 1'b0; d.addr = vic_addr; d.wdata = 8'h00; d.bank = bank_cfg;
      exp_ce.push_back(d);
    end
    predict_vic();
    acks_before = ack_count;
    n0 = cyc;
    vic_req = 1'b1;
    wait_cnt = 0;
    while (err_timeout !== 1'b1 && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("wdog_fired", err_timeout, 1);
    check("wdog_no_ack", ack_count, acks_before);
    ctl_respond = 1'b1;
    serve(1'b0, 1, 100);
    check("wdog_err_cycle", err_cyc - n0, 2 + START_TIMEOUT);
    check("wdog_err_sticky", err_timeout, 1);

    // Reset while the controller is mid-transfer.
    idle(2);
    ctl_b = 6;
    cpu_we = 1'b0; cpu_addr = 16'h2003; bank_cfg = 7'h21;
    issue_round(1'b1, 1'b0);
    wait_cnt = 0;
    while (mc_ce !== 1'b1 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("rst_ce_seen", mc_ce, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    exp_ack.delete();
    model_last = 1'b0;
    model_rd_cpu = '0;
    model_rd_vic = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {cpu_rdata, cpu_ack, vic_rdata, vic_ack, mc_ce, mc_write, mc_bank,
           mc_addr, mc_nbytes, mc_wdata, init_done, err_timeout}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // A fresh request after reset completes normally.
    ctl_b = 2;
    cpu_we = 1'b0; cpu_addr = 16'h2007; bank_cfg = 7'h09;
    issue_round(1'b1, 1'b0);
    serve(1'b0, 1, 100);

    // Arbitration with both requests held across completions: VIC, CPU, VIC, CPU.
    idle(2);
    ctl_b = 1;
    cpu_we = 1'b1; cpu_addr = 16'h2100; cpu_wdata = 8'hA5;
    vic_addr = 16'h2100; bank_cfg = 7'h33;
    for (int k = 0; k < 4; k++) begin
      if (model_last == 1'b0) predict_vic();
      else                    predict_cpu();
    end
    cpu_req = 1'b1;
    vic_req = 1'b1;
    serve(1'b1, 4, 200);

    idle(4);
    check("ce_queue_empty", exp_ce.size(), 0);
    check("ack_queue_empty", exp_ack.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
